// File: rtl/cache_req_sequencer.sv
`timescale 1ns/1ps
// Front-end for the two-level cache: buffers read addresses, issues one single-cycle read at a
// time, and returns data plus service level over valid/ready with saturating hit statistics.
module cache_req_sequencer #(
  parameter int ADDR_WIDTH = 11,
  parameter int DATA_WIDTH = 32,
  parameter int FIFO_DEPTH = 4,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [ADDR_WIDTH-1:0] in_addr,
  output logic                  cache_read,
  output logic [ADDR_WIDTH-1:0] cache_addr,
  input  logic [DATA_WIDTH-1:0] cache_read_data,
  input  logic                  cache_l1_hit,
  input  logic                  cache_l2_hit,
  output logic                  resp_valid,
  input  logic                  resp_ready,
  output logic [ADDR_WIDTH-1:0] resp_addr,
  output logic [DATA_WIDTH-1:0] resp_data,
  output logic [1:0]            resp_level,
  input  logic                  stats_clear,
  output logic [CNT_WIDTH-1:0]  cnt_total,
  output logic [CNT_WIDTH-1:0]  cnt_l1,
  output logic [CNT_WIDTH-1:0]  cnt_l2,
  output logic [CNT_WIDTH-1:0]  cnt_mem,
  output logic                  busy
);
  localparam int PTR_W = $clog2(FIFO_DEPTH);

  typedef enum logic [1:0] {IDLE, ISSUE, CAPTURE, RESP} state_t;
  state_t state, state_nxt;

  logic [FIFO_DEPTH-1:0][ADDR_WIDTH-1:0] fifo_mem;
  logic [PTR_W-1:0]                      wr_ptr, rd_ptr;
  logic [PTR_W:0]                        fifo_cnt;
  logic                                  push, pop, full, empty, capture;
  logic [ADDR_WIDTH-1:0]                 cur_addr;
  logic [1:0]                            cap_level;
  logic [3:0][CNT_WIDTH-1:0]             cnt;
  logic [3:0]                            cnt_inc;

  assign full     = (fifo_cnt == (PTR_W+1)'(FIFO_DEPTH));
  assign empty    = (fifo_cnt == '0);
  assign in_ready = !full;
  assign push     = in_valid && in_ready;
  assign pop      = (state == IDLE) && !empty;
  assign capture  = (state == CAPTURE);

  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_ptr] <= in_addr;
  end

  // Pointers wrap naturally since the depth is a power of two.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      fifo_cnt <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   fifo_cnt <= fifo_cnt + 1'b1;
        2'b01:   fifo_cnt <= fifo_cnt - 1'b1;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // CAPTURE keeps cache_read low so the cache's L2->L1 promotion write lands before the next read.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (!empty) state_nxt = ISSUE;
      ISSUE:   state_nxt = CAPTURE;
      CAPTURE: state_nxt = RESP;
      RESP:    if (resp_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst)      cur_addr <= '0;
    else if (pop) cur_addr <= fifo_mem[rd_ptr];
  end

  assign cache_read = (state == ISSUE);
  assign cache_addr = cur_addr;
  assign resp_valid = (state == RESP);
  assign busy       = (state != IDLE) || !empty;

  assign cap_level = cache_l1_hit ? 2'd0 : (cache_l2_hit ? 2'd1 : 2'd2);

  always_ff @(posedge clk) begin
    if (rst) begin
      resp_addr  <= '0;
      resp_data  <= '0;
      resp_level <= '0;
    end else if (capture) begin
      resp_addr  <= cur_addr;
      resp_data  <= cache_read_data;
      resp_level <= cap_level;
    end
  end

  // Counter order: total, L1, L2, memory. Clear beats a coincident increment.
  assign cnt_inc = {capture && (cap_level == 2'd2), capture && (cap_level == 2'd1),
                    capture && (cap_level == 2'd0), capture};

  always_ff @(posedge clk) begin
    for (int i = 0; i < 4; i++) begin
      if (rst || stats_clear)                   cnt[i] <= '0;
      else if (cnt_inc[i] && (cnt[i] != '1))    cnt[i] <= cnt[i] + 1'b1;
    end
  end

  assign cnt_total = cnt[0];
  assign cnt_l1    = cnt[1];
  assign cnt_l2    = cnt[2];
  assign cnt_mem   = cnt[3];
endmodule

// File: doc/cache_req_sequencer.md
# cache_req_sequencer

- Request front-end placed directly upstream of the 4-way two-level cache system.
- Accepts read addresses over a valid/ready handshake and buffers them in a small FIFO.
- Issues them to the cache one at a time as single-cycle read pulses, then captures the cache's registered hit flags and data.
- Returns each result with its service level over a second valid/ready handshake and keeps saturating hit/miss statistics for the simulator.

## Interface
- ADDR_WIDTH, 11, address width; matches the cache system.
- DATA_WIDTH, 32, data width; matches the cache system.
- FIFO_DEPTH, 4, request FIFO entries; power of two, ≥2.
- CNT_WIDTH, 16, width of each statistics counter.

Ports (one clock `clk`; reset `rst` is synchronous and active-high):
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  synchronous active-high reset.
- in_valid  in  1  request present.
- in_ready  out  1  FIFO can accept; equals !full.
- in_addr  in  ADDR_WIDTH  request address.
- cache_read  out  1  read strobe to the cache system.
- cache_addr  out  ADDR_WIDTH  address to the cache system.
- cache_read_data  in  DATA_WIDTH  registered data from the cache.
- cache_l1_hit  in  1  registered L1 hit flag from the cache.
- cache_l2_hit  in  1  registered L2 hit flag from the cache.
- resp_valid  out  1  response present.
- resp_ready  in  1  consumer accepts response.
- resp_addr  out  ADDR_WIDTH  address of the response.
- resp_data  out  DATA_WIDTH  returned data.
- resp_level  out  2  service level: 0 = L1, 1 = L2, 2 = memory; 3 is never driven.
- stats_clear  in  1  synchronous clear of all counters.
- cnt_total, cnt_l1, cnt_l2, cnt_mem  out  CNT_WIDTH each  completed / L1 / L2 / memory counts.
- busy  out  1  high when the FSM is not IDLE or the FIFO is non-empty.

## Operation
- **FIFO**
  - Push on in_valid && in_ready.
  - Pop only from IDLE.
  - Pointers are log2(FIFO_DEPTH) bits and wrap modulo depth; an occupancy counter is log2(FIFO_DEPTH)+1 bits.
  - A push in the same cycle as a pop is allowed whenever not full. When full, in_ready=0 and no push occurs, even if a pop happens that cycle.
- **FSM states**
  - IDLE: if FIFO non-empty, pop the head into cur_addr and go to ISSUE; otherwise stay.
  - ISSUE: cache_read=1, cache_addr=cur_addr for exactly one cycle; go to CAPTURE.
  - CAPTURE: cache_read=0. Sample the cache outputs, which the cache registered at the end of ISSUE:
    - resp_data ← cache_read_data, resp_addr ← cur_addr.
    - resp_level ← 0 if cache_l1_hit; else 1 if cache_l2_hit; else 2.
    - Increment cnt_total and the matching level counter.
    - Go to RESP.
  - RESP: resp_valid=1 and response fields held stable. On resp_valid && resp_ready go to IDLE; otherwise hold indefinitely.
- cache_read is asserted only in ISSUE.
  - Keeping it low in CAPTURE lets the cache's L2→L1 promotion write complete before the next read. The promotion write lands at the CAPTURE→RESP edge, so the next ISSUE is always safe.
- cache_addr equals cur_addr in every state; only ISSUE matters.
- **Counters**
  - Saturate at 2^CNT_WIDTH−1; no wrap.
  - stats_clear zeroes all four. If it coincides with a CAPTURE increment, clear wins and the counters read 0 next cycle.
- Only one request is in flight; ordering is strictly FIFO.

## Timing
- Reset values: in_ready=1, cache_read=0, cache_addr=0, resp_valid=0, resp_addr=0, resp_data=0, resp_level=0, all counters 0, busy=0. FSM=IDLE, FIFO empty.
- Reset mid-operation (any state, including RESP with a pending response): the next edge forces all of the above. Buffered requests and the pending response are discarded, and cache_read is low from the first reset cycle.
- Latency, with the request accepted in cycle 0, FIFO empty and FSM IDLE:
  - pop in cycle 1;
  - cache_read=1 in cycle 2;
  - capture in cycle 3;
  - resp_valid=1 from cycle 4.
- Throughput with resp_ready tied high: one response every 4 cycles.
- Backpressure: while resp_ready=0, the FIFO keeps filling until in_ready drops at FIFO_DEPTH entries.
- resp_valid deasserts the cycle after the handshake. The earliest next resp_valid is 4 cycles after that handshake edge.

## Test plan
- **L1 hit:** cache stub returns l1_hit=1, data 0x12345678, for addr 0x010 sent in cycle 0 → cache_read pulse only in cycle 2; resp_valid in cycle 4 with addr 0x010, data 0x12345678, level 0; cnt_l1=1, cnt_total=1.
- **L2 hit then miss:** addr 0x020 gets l2_hit=1, data 0xA5A5A5A5; then addr 0x7FF gets no hit, data 0xCAFEBABE → levels 1 then 2 in order; cnt_l2=1, cnt_mem=1, cnt_total=2.
- **Backpressure/full:** resp_ready=0 while pushing 6 addresses back to back → first popped, 4 buffered, in_ready=0 after the fifth accept, sixth held off. Releasing resp_ready drains all 5 responses in order, one per 4 cycles.
- **Saturation and clear:** CNT_WIDTH=2 with 5 L1 hits → cnt_l1=3, cnt_total=3. stats_clear asserted in a CAPTURE cycle → all counters 0 next cycle.
- **Reset mid-flight:** rst asserted during RESP with 2 entries queued → next cycle resp_valid=0, in_ready=1, busy=0, counters 0, and no further cache_read pulses.
